// File: rtl/memory_responder.sv
// rtl/memory_responder.sv - CPU memory bus responder: RAM, two display banks, I/O window with req/ack
module memory_responder #(
  parameter int RAM_DEPTH  = 640,
  parameter int VRAM_DEPTH = 80,
  parameter int IO_TIMEOUT = 15
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        memory_write_en,
  input  logic        memory_read_en,
  input  logic [11:0] memory_addr,
  input  logic [3:0]  memory_write_data,
  output logic [3:0]  memory_read_data,
  output logic        busy,
  input  logic [7:0]  disp_addr,
  output logic [3:0]  disp_data,
  output logic        io_req,
  output logic        io_write,
  output logic [6:0]  io_addr,
  output logic [3:0]  io_wdata,
  input  logic [3:0]  io_rdata,
  input  logic        io_ack,
  output logic        io_timeout
);

  localparam int              RAM_AW   = $clog2(RAM_DEPTH);
  localparam int              CW       = $clog2(IO_TIMEOUT + 1);
  localparam logic [11:0]     RAM_END  = 12'(RAM_DEPTH);
  localparam logic [6:0]      VRAM_LIM = 7'(VRAM_DEPTH);
  // Last WAIT count value before forcing completion, so io_req stays up IO_TIMEOUT cycles
  localparam logic [CW-1:0]   CNT_LAST = CW'(IO_TIMEOUT - 1);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_DONE} state_t;

  logic [3:0] ram   [RAM_DEPTH];
  logic [3:0] vram0 [VRAM_DEPTH];
  logic [3:0] vram1 [VRAM_DEPTH];

  state_t        state, state_n;
  logic [CW-1:0] cnt, cnt_n;
  logic          io_req_n, io_write_n, busy_n, timeout_n;
  logic [6:0]    io_addr_n;
  logic [3:0]    io_wdata_n, rdata_n;

  logic       ram_hit, vram0_hit, vram1_hit, io_hit;
  logic       mem_wr;
  logic [3:0] mem_rd;
  logic [3:0] disp_rd;

  // Window decode; VRAM banks and the I/O window all sit on 128-nibble boundaries
  assign ram_hit   = memory_addr < RAM_END;
  assign vram0_hit = (memory_addr[11:7] == 5'b11100) && (memory_addr[6:0] < VRAM_LIM);
  assign vram1_hit = (memory_addr[11:7] == 5'b11101) && (memory_addr[6:0] < VRAM_LIM);
  assign io_hit    = (memory_addr[11:7] == 5'b11110);

  // Any strobe while an I/O transaction is in flight is dropped, RAM writes included
  assign mem_wr = memory_write_en && !busy;

  // Old-data read mux for the CPU port; unmapped addresses read as zero
  always_comb begin
    mem_rd = 4'h0;
    if (ram_hit)
      mem_rd = ram[memory_addr[RAM_AW-1:0]];
    else if (vram0_hit)
      mem_rd = vram0[memory_addr[6:0]];
    else if (vram1_hit)
      mem_rd = vram1[memory_addr[6:0]];
  end

  // Old-data read mux for the display scan port
  always_comb begin
    disp_rd = 4'h0;
    if (disp_addr[6:0] < VRAM_LIM)
      disp_rd = disp_addr[7] ? vram1[disp_addr[6:0]] : vram0[disp_addr[6:0]];
  end

  // Nibble storage; contents survive reset
  always_ff @(posedge clk) begin
    if (mem_wr && ram_hit)
      ram[memory_addr[RAM_AW-1:0]] <= memory_write_data;
    if (mem_wr && vram0_hit)
      vram0[memory_addr[6:0]] <= memory_write_data;
    if (mem_wr && vram1_hit)
      vram1[memory_addr[6:0]] <= memory_write_data;
  end

  // Display port register, free-running every cycle
  always_ff @(posedge clk) begin
    if (reset)
      disp_data <= 4'h0;
    else
      disp_data <= disp_rd;
  end

  // Control state and all CPU-visible registers
  always_ff @(posedge clk) begin
    if (reset) begin
      state            <= S_IDLE;
      cnt              <= '0;
      io_req           <= 1'b0;
      io_write         <= 1'b0;
      io_addr          <= 7'h00;
      io_wdata         <= 4'h0;
      busy             <= 1'b0;
      io_timeout       <= 1'b0;
      memory_read_data <= 4'h0;
    end else begin
      state            <= state_n;
      cnt              <= cnt_n;
      io_req           <= io_req_n;
      io_write         <= io_write_n;
      io_addr          <= io_addr_n;
      io_wdata         <= io_wdata_n;
      busy             <= busy_n;
      io_timeout       <= timeout_n;
      memory_read_data <= rdata_n;
    end
  end

  // Next-state: memory reads complete in IDLE, I/O accesses run IDLE -> WAIT -> DONE
  always_comb begin
    state_n    = state;
    cnt_n      = cnt;
    io_req_n   = io_req;
    io_write_n = io_write;
    io_addr_n  = io_addr;
    io_wdata_n = io_wdata;
    busy_n     = busy;
    timeout_n  = io_timeout;
    rdata_n    = memory_read_data;
    case (state)
      S_IDLE: begin
        if (io_hit && (memory_write_en || memory_read_en)) begin
          // A combined write+read to I/O becomes a single write
          state_n    = S_WAIT;
          cnt_n      = '0;
          io_req_n   = 1'b1;
          busy_n     = 1'b1;
          io_write_n = memory_write_en;
          io_addr_n  = memory_addr[6:0];
          io_wdata_n = memory_write_data;
        end else if (memory_read_en) begin
          rdata_n = mem_rd;
        end
      end
      S_WAIT: begin
        // Ack wins over a timeout landing in the same cycle
        if (io_ack) begin
          io_req_n = 1'b0;
          state_n  = S_DONE;
          if (!io_write)
            rdata_n = io_rdata;
        end else if (cnt == CNT_LAST) begin
          io_req_n  = 1'b0;
          timeout_n = 1'b1;
          state_n   = S_DONE;
          if (!io_write)
            rdata_n = 4'hF;
        end else begin
          cnt_n = cnt + CW'(1);
        end
      end
      S_DONE: begin
        busy_n  = 1'b0;
        state_n = S_IDLE;
      end
      default: state_n = S_IDLE;
    endcase
  end

endmodule

// File: tb/tb_memory_responder.sv
// tb/tb_memory_responder.sv - self-checking bench for memory_responder
module tb_memory_responder;

  localparam int RAM_DEPTH  = 640;
  localparam int VRAM_DEPTH = 80;
  localparam int IO_TIMEOUT = 15;

  logic        clk = 1'b0;
  logic        reset;
  logic        memory_write_en, memory_read_en;
  logic [11:0] memory_addr;
  logic [3:0]  memory_write_data, memory_read_data;
  logic        busy;
  logic [7:0]  disp_addr;
  logic [3:0]  disp_data;
  logic        io_req, io_write;
  logic [6:0]  io_addr;
  logic [3:0]  io_wdata, io_rdata;
  logic        io_ack, io_timeout;

  int passed = 0;
  int total  = 0;

  logic [3:0] mdl [0:4095];

  memory_responder #(
    .RAM_DEPTH(RAM_DEPTH), .VRAM_DEPTH(VRAM_DEPTH), .IO_TIMEOUT(IO_TIMEOUT)
  ) dut (
    .clk(clk), .reset(reset),
    .memory_write_en(memory_write_en), .memory_read_en(memory_read_en),
    .memory_addr(memory_addr), .memory_write_data(memory_write_data),
    .memory_read_data(memory_read_data), .busy(busy),
    .disp_addr(disp_addr), .disp_data(disp_data),
    .io_req(io_req), .io_write(io_write), .io_addr(io_addr), .io_wdata(io_wdata),
    .io_rdata(io_rdata), .io_ack(io_ack), .io_timeout(io_timeout)
  );

  always #5 clk = ~clk;

  function automatic bit mapped(input int a);
    return (a < RAM_DEPTH) ||
           (a >= 'hE00 && a < 'hE00 + VRAM_DEPTH) ||
           (a >= 'hE80 && a < 'hE80 + VRAM_DEPTH);
  endfunction

  function automatic logic [3:0] model_read(input int a);
    return mapped(a) ? mdl[a] : 4'h0;
  endfunction

  function automatic logic [3:0] model_disp(input int da);
    int idx = da % 128;
    int bank = da / 128;
    return (idx < VRAM_DEPTH) ? mdl['hE00 + bank * 128 + idx] : 4'h0;
  endfunction

  function automatic logic [11:0] rand_addr();
    int a;
    case ($urandom_range(0, 4))
      0, 1:    a = $urandom_range(0, RAM_DEPTH + 60);
      2:       a = 'hE00 + $urandom_range(0, 127);
      3:       a = 'hE80 + $urandom_range(0, 127);
      default: begin
        a = $urandom_range(0, 4095);
        if (a >= 'hF00 && a < 'hF80) a = a + 'h80;
      end
    endcase
    return 12'(a);
  endfunction

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  task automatic do_write(input logic [11:0] a, input logic [3:0] d);
    memory_write_en   = 1'b1;
    memory_read_en    = 1'b0;
    memory_addr       = a;
    memory_write_data = d;
    if (mapped(int'(a))) mdl[a] = d;
    tick();
    memory_write_en = 1'b0;
  endtask

  task automatic do_read(input logic [11:0] a, output logic [3:0] d);
    memory_read_en = 1'b1;
    memory_addr    = a;
    tick();
    memory_read_en = 1'b0;
    d = memory_read_data;
  endtask

  initial begin
    logic [3:0] rd, exp_rd, exp_disp;
    logic       we, re;
    logic [11:0] a;
    logic [3:0]  d;
    logic [7:0]  da;
    int          n;

    reset = 1'b1;
    memory_write_en = 1'b0; memory_read_en = 1'b0;
    memory_addr = 12'h000; memory_write_data = 4'h0;
    disp_addr = 8'h00; io_rdata = 4'h0; io_ack = 1'b0;
    for (int i = 0; i < 4096; i++) mdl[i] = 4'h0;
    repeat (3) tick();

    check("rst_rdata", memory_read_data, 4'h0);
    check("rst_busy", busy, 1'b0);
    check("rst_io_req", io_req, 1'b0);
    check("rst_io_timeout", io_timeout, 1'b0);
    check("rst_disp", disp_data, 4'h0);
    check("rst_io_addr", io_addr, 7'h00);
    reset = 1'b0;
    tick();

    // Give every mapped nibble a known value
    for (int i = 0; i < RAM_DEPTH; i++) do_write(12'(i), 4'($urandom_range(0, 15)));
    for (int i = 0; i < VRAM_DEPTH; i++) begin
      do_write(12'('hE00 + i), 4'($urandom_range(0, 15)));
      do_write(12'('hE80 + i), 4'($urandom_range(0, 15)));
    end

    do_write(12'h005, 4'hA);
    do_read(12'h005, rd);
    check("ram_rd_005", rd, 4'hA);
    check("ram_busy", busy, 1'b0);

    do_write(12'h010, 4'h7);
    memory_write_en = 1'b1; memory_read_en = 1'b1;
    memory_addr = 12'h010; memory_write_data = 4'h3;
    mdl[12'h010] = 4'h3;
    tick();
    memory_write_en = 1'b0; memory_read_en = 1'b0;
    check("rw_same_old", memory_read_data, 4'h7);
    do_read(12'h010, rd);
    check("rw_same_new", rd, 4'h3);

    do_write(12'hE85, 4'h9);
    disp_addr = 8'h85;
    tick();
    check("disp_e85", disp_data, 4'h9);
    do_write(12'h300, 4'h1);
    do_read(12'h300, rd);
    check("unmapped_300", rd, 4'h0);

    do_write(12'hE05, 4'h4);
    disp_addr = 8'h05;
    do_write(12'hE05, 4'hB);
    check("disp_same_old", disp_data, 4'h4);
    tick();
    check("disp_same_new", disp_data, 4'hB);

    do_write(12'(RAM_DEPTH - 1), 4'h5);
    do_read(12'(RAM_DEPTH - 1), rd);
    check("ram_last", rd, 4'h5);
    do_write(12'(RAM_DEPTH), 4'h6);
    do_read(12'(RAM_DEPTH), rd);
    check("ram_end_unmapped", rd, 4'h0);
    do_read(12'('hE00 + VRAM_DEPTH), rd);
    check("vram0_end_unmapped", rd, 4'h0);
    do_read(12'('hE80 + VRAM_DEPTH - 1), rd);
    check("vram1_last", rd, mdl['hE80 + VRAM_DEPTH - 1]);
    disp_addr = 8'(VRAM_DEPTH);
    tick();
    check("disp_idx_oob", disp_data, 4'h0);

    // Random mix of CPU writes/reads and display scans against the array model
    do_read(12'h000, rd);
    exp_rd = mdl[0];
    check("rand_seed_rd", rd, exp_rd);
    for (int i = 0; i < 400; i++) begin
      we = 1'($urandom_range(0, 1));
      re = 1'($urandom_range(0, 1));
      a  = rand_addr();
      d  = 4'($urandom_range(0, 15));
      da = 8'($urandom_range(0, 255));
      exp_disp = model_disp(int'(da));
      if (re) exp_rd = model_read(int'(a));
      if (we && mapped(int'(a))) mdl[a] = d;
      memory_write_en = we; memory_read_en = re;
      memory_addr = a; memory_write_data = d; disp_addr = da;
      tick();
      memory_write_en = 1'b0; memory_read_en = 1'b0;
      check($sformatf("rand_rd_%0d", i), memory_read_data, exp_rd);
      check($sformatf("rand_disp_%0d", i), disp_data, exp_disp);
      check($sformatf("rand_busy_%0d", i), busy, 1'b0);
    end

    // I/O read acked in the third WAIT cycle
    memory_read_en = 1'b1; memory_addr = 12'hF12;
    tick();
    memory_read_en = 1'b0;
    check("io_rd_req", io_req, 1'b1);
    check("io_rd_addr", io_addr, 7'h12);
    check("io_rd_dir", io_write, 1'b0);
    check("io_rd_busy", busy, 1'b1);
    tick(); tick();
    io_ack = 1'b1; io_rdata = 4'h6;
    tick();
    io_ack = 1'b0;
    check("io_rd_req_drop", io_req, 1'b0);
    check("io_rd_data", memory_read_data, 4'h6);
    check("io_rd_busy_done", busy, 1'b1);
    tick();
    check("io_rd_busy_low", busy, 1'b0);

    // I/O write with read also strobed: a single write, read data untouched
    memory_write_en = 1'b1; memory_read_en = 1'b1;
    memory_addr = 12'hF7F; memory_write_data = 4'hC;
    tick();
    memory_write_en = 1'b0; memory_read_en = 1'b0;
    check("io_wr_req", io_req, 1'b1);
    check("io_wr_dir", io_write, 1'b1);
    check("io_wr_addr", io_addr, 7'h7F);
    check("io_wr_data", io_wdata, 4'hC);
    io_ack = 1'b1; io_rdata = 4'h3;
    tick();
    io_ack = 1'b0;
    check("io_wr_req_drop", io_req, 1'b0);
    check("io_wr_rdata_hold", memory_read_data, 4'h6);
    tick();
    check("io_wr_busy_low", busy, 1'b0);

    // I/O read never acked; a RAM write during WAIT must be dropped
    memory_read_en = 1'b1; memory_addr = 12'hF40;
    tick();
    memory_read_en = 1'b0;
    memory_write_en = 1'b1; memory_addr = 12'h005;
    memory_write_data = ~mdl[12'h005];
    n = 0;
    for (int i = 0; i < 40 && io_req; i++) begin
      n++;
      tick();
      memory_write_en = 1'b0;
    end
    memory_write_en = 1'b0;
    check("to_req_cycles", n, IO_TIMEOUT);
    check("to_data", memory_read_data, 4'hF);
    check("to_flag", io_timeout, 1'b1);
    tick();
    check("to_busy_low", busy, 1'b0);
    do_read(12'h005, rd);
    check("busy_write_dropped", rd, mdl[12'h005]);
    check("to_sticky", io_timeout, 1'b1);

    // Reset in the middle of an I/O transaction
    memory_read_en = 1'b1; memory_addr = 12'hF01;
    tick();
    memory_read_en = 1'b0;
    check("rw_req_up", io_req, 1'b1);
    reset = 1'b1;
    tick();
    check("rw_req", io_req, 1'b0);
    check("rw_busy", busy, 1'b0);
    check("rw_rdata", memory_read_data, 4'h0);
    check("rw_timeout", io_timeout, 1'b0);
    reset = 1'b0;
    tick();
    do_read(12'h005, rd);
    check("rw_ram_kept", rd, mdl[12'h005]);
    do_read(12'hE85, rd);
    check("rw_vram_kept", rd, mdl[12'hE85]);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
